auth_session_controller: RTL and testbench

Sequences one challenge-response authentication session per request. Generates each 4-bit challenge from an internal LFSR and offers it to the client over a valid/ready handshake. Waits for the client response with a timeout and checks it against challenge XOR secret key. Tracks consecutive failures and locks the port out after too many; sits between the host "start" logic and the client-facing challenge/response link.

---
 rtl/auth_pkg.sv | 23 ++
 rtl/auth_lfsr4.sv | 21 ++
 rtl/auth_session_controller.sv | 132 +++++++++++++
 tb/tb_auth_session_controller.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/auth_pkg.sv
// Shared types and defaults for the challenge-response session controller:
// FSM state encoding, reset values and the 4-bit LFSR feedback.
package auth_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RESP,
    S_CHECK,
    S_GRANT,
    S_FAIL,
    S_LOCKED
  } state_t;

  localparam logic [3:0] KEY_RESET_DEFAULT = 4'b1100;
  localparam logic [3:0] LFSR_SEED_DEFAULT = 4'b1001;

  // Shift left, feed back bit3^bit2; never reaches zero from a nonzero seed.
  function automatic logic [3:0] lfsr_next(input logic [3:0] value);
    return {value[2:0], value[3] ^ value[2]};
  endfunction

endpackage

// File: rtl/auth_lfsr4.sv
// 4-bit challenge generator: seeded on reset, steps once per advance pulse.
module auth_lfsr4 import auth_pkg::*; #(
  parameter logic [3:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       advance,
  output logic [3:0] value
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of process ordering in simulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= SEED;
    end else if (advance) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/auth_session_controller.sv
// One challenge-response authentication session per start request, with
// response timeout, consecutive-failure tracking and timed lockout.
module auth_session_controller import auth_pkg::*; #(
  parameter logic [3:0] KEY_RESET   = KEY_RESET_DEFAULT,
  parameter logic [3:0] LFSR_SEED   = LFSR_SEED_DEFAULT,
  parameter int         TIMEOUT     = 16,
  parameter int         MAX_FAILS   = 3,
  parameter int         LOCK_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       key_load,
  input  logic [3:0] key_in,
  output logic       chal_valid,
  input  logic       chal_ready,
  output logic [3:0] challenge,
  input  logic       resp_valid,
  input  logic [3:0] response,
  output logic       auth_ok,
  output logic       auth_fail,
  output logic       busy,
  output logic       locked,
  output logic [1:0] fail_count
);

  // One counter serves both the response timeout and the lockout period.
  localparam int TIMER_MAX = (TIMEOUT > LOCK_CYCLES) ? TIMEOUT : LOCK_CYCLES;
  localparam int TIMER_W   = (TIMER_MAX > 2) ? $clog2(TIMER_MAX) : 1;
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] LOCK_LAST    = TIMER_W'(LOCK_CYCLES - 1);
  localparam logic [1:0]         FAILS_MAX    = 2'(MAX_FAILS);

  state_t             state_q, state_d;
  logic [3:0]         key_q, chal_q, resp_q, lfsr_value;
  logic [TIMER_W-1:0] timer_q;
  logic [1:0]         fail_plus;
  logic               handshake, timer_clear, timer_inc;
  logic               fail_inc, fail_clear, key_we, resp_we;

  auth_lfsr4 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (handshake),
    .value   (lfsr_value)
  );

  assign fail_plus = (fail_count == FAILS_MAX) ? fail_count : fail_count + 2'd1;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path through
    // the case statement leaves a signal unassigned and infers a latch.
    state_d     = state_q;
    handshake   = 1'b0;
    timer_clear = 1'b0;
    timer_inc   = 1'b0;
    fail_inc    = 1'b0;
    fail_clear  = 1'b0;
    key_we      = 1'b0;
    resp_we     = 1'b0;
    case (state_q)
      S_IDLE: begin
        key_we = key_load;
        if (start) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (chal_ready) begin
          handshake   = 1'b1;
          timer_clear = 1'b1;
          state_d     = S_WAIT_RESP;
        end
      end
      S_WAIT_RESP: begin
        if (resp_valid) begin
          resp_we = 1'b1;
          state_d = S_CHECK;
        end else if (timer_q == TIMEOUT_LAST) begin
          state_d = S_FAIL;
        end else begin
          timer_inc = 1'b1;
        end
      end
      S_CHECK: state_d = ((chal_q ^ key_q) == resp_q) ? S_GRANT : S_FAIL;
      S_GRANT: begin
        fail_clear = 1'b1;
        state_d    = S_IDLE;
      end
      S_FAIL: begin
        fail_inc    = 1'b1;
        timer_clear = 1'b1;
        state_d     = (fail_plus == FAILS_MAX) ? S_LOCKED : S_IDLE;
      end
      S_LOCKED: begin
        if (timer_q == LOCK_LAST) begin
          fail_clear = 1'b1;
          state_d    = S_IDLE;
        end else begin
          timer_inc = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      key_q      <= KEY_RESET;
      chal_q     <= '0;
      resp_q     <= '0;
      timer_q    <= '0;
      fail_count <= '0;
    end else begin
      state_q <= state_d;
      if (key_we)  key_q  <= key_in;
      if (handshake) chal_q <= lfsr_value;
      if (resp_we) resp_q <= response;
      if (timer_clear)    timer_q <= '0;
      else if (timer_inc) timer_q <= timer_q + 1'b1;
      if (fail_clear)    fail_count <= '0;
      else if (fail_inc) fail_count <= fail_plus;
    end
  end

  assign chal_valid = (state_q == S_ISSUE);
  assign challenge  = lfsr_value;
  assign auth_ok    = (state_q == S_GRANT);
  assign auth_fail  = (state_q == S_FAIL);
  assign busy       = (state_q != S_IDLE);
  assign locked     = (state_q == S_LOCKED);

endmodule

// File: tb/tb_auth_session_controller.sv
// Directed bench for auth_session_controller; each task checks its own scenario.
module tb_auth_session_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, key_load = 1'b0, chal_ready = 1'b0, resp_valid = 1'b0;
  logic [3:0] key_in = '0, response = '0;
  logic       chal_valid, auth_ok, auth_fail, busy, locked;
  logic [3:0] challenge;
  logic [1:0] fail_count;

  int checks = 0;
  int errors = 0;

  auth_session_controller dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .key_load   (key_load),
    .key_in     (key_in),
    .chal_valid (chal_valid),
    .chal_ready (chal_ready),
    .challenge  (challenge),
    .resp_valid (resp_valid),
    .response   (response),
    .auth_ok    (auth_ok),
    .auth_fail  (auth_fail),
    .busy       (busy),
    .locked     (locked),
    .fail_count (fail_count)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; key_load = 1'b0; key_in = '0;
    chal_ready = 1'b0; resp_valid = 1'b0; response = '0;
    step(); step();
    reset = 1'b0;
    step();
  endtask

  // Full session with chal_ready high and the response in the first WAIT_RESP
  // cycle; reports the challenge seen and the outcome pulses in the GRANT/FAIL slot.
  task automatic session(input logic [3:0] resp, output logic [3:0] chal,
                         output logic ok, output logic fl);
    start = 1'b1; chal_ready = 1'b1;
    step();
    start = 1'b0; chal = challenge;
    step();
    resp_valid = 1'b1; response = resp;
    step();
    resp_valid = 1'b0;
    step();
    ok = auth_ok; fl = auth_fail;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({chal_valid, auth_ok, auth_fail, busy, locked} !== 5'b0) begin errors++;
      $display("FAIL reset_flags got %b want 00000", {chal_valid, auth_ok, auth_fail, busy, locked}); end
    checks++; if (fail_count !== 2'd0) begin errors++;
      $display("FAIL reset_fail_count got %0d want 0", fail_count); end
    checks++; if (challenge !== 4'b1001) begin errors++;
      $display("FAIL reset_challenge got %b want 1001", challenge); end
  endtask

  task automatic test_pass();
    logic [3:0] c; logic ok, fl;
    do_reset();
    session(4'b0101, c, ok, fl);
    checks++; if (c !== 4'b1001) begin errors++; $display("FAIL pass_chal got %b want 1001", c); end
    checks++; if ({ok, fl} !== 2'b10) begin errors++; $display("FAIL pass_result got %b want 10", {ok, fl}); end
    checks++; if (auth_ok !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL pass_pulse_end got ok=%b busy=%b want 0 0", auth_ok, busy); end
    checks++; if (fail_count !== 2'd0) begin errors++; $display("FAIL pass_fail_count got %0d want 0", fail_count); end
    checks++; if (challenge !== 4'b0011) begin errors++; $display("FAIL pass_next_chal got %b want 0011", challenge); end
    session(4'b1111, c, ok, fl);
    checks++; if ({c, ok, fl} !== {4'b0011, 2'b10}) begin errors++;
      $display("FAIL pass_second got chal=%b ok=%b fail=%b want 0011 1 0", c, ok, fl); end
  endtask

  task automatic test_mismatch();
    logic [3:0] c; logic ok, fl;
    do_reset();
    session(4'b1111, c, ok, fl);
    checks++; if ({c, ok, fl} !== {4'b1001, 2'b01}) begin errors++;
      $display("FAIL mismatch_result got chal=%b ok=%b fail=%b want 1001 0 1", c, ok, fl); end
    checks++; if (fail_count !== 2'd1) begin errors++; $display("FAIL mismatch_fail_count got %0d want 1", fail_count); end
    checks++; if ({busy, locked, auth_fail} !== 3'b000) begin errors++;
      $display("FAIL mismatch_idle got busy/locked/fail=%b want 000", {busy, locked, auth_fail}); end
  endtask

  task automatic test_lockout();
    logic [3:0] c; logic ok, fl; logic saw_cv; int n;
    do_reset();
    session(4'b1111, c, ok, fl);
    session(4'b0000, c, ok, fl);
    checks++; if ({c, fl, fail_count} !== {4'b0011, 1'b1, 2'd2}) begin errors++;
      $display("FAIL lock_second got chal=%b fail=%b count=%0d want 0011 1 2", c, fl, fail_count); end
    session(4'b0000, c, ok, fl);
    checks++; if ({c, fl} !== {4'b0110, 1'b1}) begin errors++;
      $display("FAIL lock_third got chal=%b fail=%b want 0110 1", c, fl); end
    checks++; if ({locked, busy, fail_count} !== {2'b11, 2'd3}) begin errors++;
      $display("FAIL lock_enter got locked=%b busy=%b count=%0d want 1 1 3", locked, busy, fail_count); end
    // start and key_load pulled high during the first part of the lockout
    n = 0; saw_cv = 1'b0;
    start = 1'b1; key_load = 1'b1; key_in = 4'b0000;
    while (locked && n < 200) begin
      n++;
      saw_cv |= chal_valid;
      if (n == 30) begin start = 1'b0; key_load = 1'b0; end
      step();
    end
    start = 1'b0; key_load = 1'b0;
    checks++; if (n !== 64) begin errors++; $display("FAIL lock_duration got %0d want 64", n); end
    checks++; if (saw_cv !== 1'b0) begin errors++; $display("FAIL lock_start_ignored got chal_valid=%b want 0", saw_cv); end
    checks++; if ({busy, fail_count} !== {1'b0, 2'd0}) begin errors++;
      $display("FAIL lock_exit got busy=%b count=%0d want 0 0", busy, fail_count); end
    session(4'b0001, c, ok, fl);
    checks++; if ({c, ok, fl} !== {4'b1101, 2'b10}) begin errors++;
      $display("FAIL lock_after_session got chal=%b ok=%b fail=%b want 1101 1 0", c, ok, fl); end
  endtask

  task automatic test_timeout_backpressure();
    int n;
    do_reset();
    chal_ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if ({chal_valid, challenge} !== {1'b1, 4'b1001}) begin errors++;
        $display("FAIL bp_hold[%0d] got valid=%b chal=%b want 1 1001", i, chal_valid, challenge); end
      step();
    end
    chal_ready = 1'b1;
    step();
    checks++; if ({chal_valid, challenge} !== {1'b0, 4'b0011}) begin errors++;
      $display("FAIL bp_handshake got valid=%b chal=%b want 0 0011", chal_valid, challenge); end
    n = 0;
    while (!auth_fail && n < 40) begin n++; step(); end
    checks++; if (n !== 16) begin errors++; $display("FAIL timeout_cycles got %0d want 16", n); end
    step();
    checks++; if ({busy, fail_count} !== {1'b0, 2'd1}) begin errors++;
      $display("FAIL timeout_after got busy=%b count=%0d want 0 1", busy, fail_count); end
    // response arriving in the last allowed cycle (timer=15)
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    repeat (15) step();
    resp_valid = 1'b1; response = 4'b1111;
    checks++; if ({busy, auth_fail} !== 2'b10) begin errors++;
      $display("FAIL late_wait got busy=%b fail=%b want 1 0", busy, auth_fail); end
    step();
    resp_valid = 1'b0;
    checks++; if ({busy, auth_ok, auth_fail} !== 3'b100) begin errors++;
      $display("FAIL late_check got busy/ok/fail=%b want 100", {busy, auth_ok, auth_fail}); end
    step();
    checks++; if (auth_ok !== 1'b1) begin errors++; $display("FAIL late_grant got %b want 1", auth_ok); end
    step();
    checks++; if (fail_count !== 2'd0) begin errors++; $display("FAIL late_fail_count got %0d want 0", fail_count); end
  endtask

  task automatic test_key_load();
    logic [3:0] c; logic ok, fl;
    do_reset();
    key_load = 1'b1; key_in = 4'b0011;
    step();
    key_load = 1'b0;
    session(4'b1010, c, ok, fl);
    checks++; if ({c, ok, fl} !== {4'b1001, 2'b10}) begin errors++;
      $display("FAIL key_load_session got chal=%b ok=%b fail=%b want 1001 1 0", c, ok, fl); end
    // key_load together with start: the session uses the new key 0101
    key_load = 1'b1; key_in = 4'b0101; start = 1'b1; chal_ready = 1'b1;
    step();
    key_load = 1'b0; start = 1'b0;
    checks++; if (challenge !== 4'b0011) begin errors++; $display("FAIL key_same_chal got %b want 0011", challenge); end
    step();
    key_load = 1'b1; key_in = 4'b1111; resp_valid = 1'b1; response = 4'b0110;
    step();
    resp_valid = 1'b0;
    step();
    checks++; if (auth_ok !== 1'b1) begin errors++; $display("FAIL key_with_start got ok=%b want 1", auth_ok); end
    key_load = 1'b0;
    step();
    session(4'b0011, c, ok, fl);
    checks++; if ({c, ok, fl} !== {4'b0110, 2'b10}) begin errors++;
      $display("FAIL key_busy_ignored got chal=%b ok=%b fail=%b want 0110 1 0", c, ok, fl); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] c; logic ok, fl;
    do_reset();
    session(4'b1111, c, ok, fl);
    session(4'b0000, c, ok, fl);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    checks++; if ({busy, fail_count} !== {1'b1, 2'd2}) begin errors++;
      $display("FAIL rst_mid_pre got busy=%b count=%0d want 1 2", busy, fail_count); end
    reset = 1'b1;
    #2;
    checks++; if ({chal_valid, auth_ok, auth_fail, busy, locked, fail_count} !== 7'b0) begin errors++;
      $display("FAIL rst_mid_async got %b want 0000000", {chal_valid, auth_ok, auth_fail, busy, locked, fail_count}); end
    checks++; if (challenge !== 4'b1001) begin errors++; $display("FAIL rst_mid_chal got %b want 1001", challenge); end
    step();
    reset = 1'b0;
    step();
    session(4'b0101, c, ok, fl);
    checks++; if ({c, ok, fl} !== {4'b1001, 2'b10}) begin errors++;
      $display("FAIL rst_mid_key got chal=%b ok=%b fail=%b want 1001 1 0", c, ok, fl); end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_mismatch();
    test_lockout();
    test_timeout_backpressure();
    test_key_load();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
